// File: rtl/beep_sequencer.sv
// beep_sequencer
// Burst scheduler that gates the buzzer's square-wave generator. After a start
// request it drives the generator's active-low enable through reps bursts.
// Each burst is on_cycles cycles with the tone on. Bursts are separated by
// off_cycles cycles of silence. There is no silent gap after the last burst.
// The block finishes with a one-cycle done pulse.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; burst index holds its last value
// ON    | tone burst in progress, generator enabled (gen_en_n = 0)
// OFF   | silent gap between bursts (gen_en_n = 1)
// FIN   | one-cycle completion, done = 1
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start, i_abort  request pulse (sampled in IDLE), abort level
//   i_on_cycles       tone-on length per burst   (latched at start)
//   i_off_cycles      gap length between bursts  (latched at start)
//   i_reps            number of bursts           (latched at start)
//   o_gen_en_n        generator enable, active low
//   o_busy            high whenever not IDLE
//   o_done            one-cycle pulse on normal completion
//   o_burst_idx       0-based index of the current or last burst
module beep_sequencer #(
  parameter int DUR_W = 32,
  parameter int REP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [DUR_W-1:0] i_on_cycles,
  input  logic [DUR_W-1:0] i_off_cycles,
  input  logic [REP_W-1:0] i_reps,
  output logic             o_gen_en_n,
  output logic             o_busy,
  output logic             o_done,
  output logic [REP_W-1:0] o_burst_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [DUR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DUR_W-1:0] r_on, w_on_nxt;
  logic [DUR_W-1:0] r_off, w_off_nxt;
  logic [REP_W-1:0] r_reps, w_reps_nxt;
  logic [REP_W-1:0] r_idx, w_idx_nxt;
  logic             r_gen_en_n, w_gen_en_n_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_on       <= '0;
      r_off      <= '0;
      r_reps     <= '0;
      r_idx      <= '0;
      r_gen_en_n <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_on       <= w_on_nxt;
      r_off      <= w_off_nxt;
      r_reps     <= w_reps_nxt;
      r_idx      <= w_idx_nxt;
      r_gen_en_n <= w_gen_en_n_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // r_reps is at least 1 whenever ON is reached, so the subtraction cannot wrap.
  assign w_last = (r_idx == (r_reps - REP_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_on_nxt    = r_on;
    w_off_nxt   = r_off;
    w_reps_nxt  = r_reps;
    w_idx_nxt   = r_idx;

    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_on_nxt   = i_on_cycles;
          w_off_nxt  = i_off_cycles;
          w_reps_nxt = i_reps;
          w_idx_nxt  = '0;
          if ((i_reps == '0) || (i_on_cycles == '0)) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = i_on_cycles - DUR_W'(1);
          end
        end
      end
      S_ON: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          if (w_last) begin
            w_state_nxt = S_FIN;
          end else if (r_off == '0) begin
            // Back-to-back bursts: stay in ON and start the next burst.
            w_idx_nxt = r_idx + REP_W'(1);
            w_cnt_nxt = r_on - DUR_W'(1);
          end else begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = r_off - DUR_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - DUR_W'(1);
        end
      end
      S_OFF: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = r_on - DUR_W'(1);
          w_idx_nxt   = r_idx + REP_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - DUR_W'(1);
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are computed from the state being entered.
    w_gen_en_n_nxt = (w_state_nxt != S_ON);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = (w_state_nxt == S_FIN);
  end

  assign o_gen_en_n  = r_gen_en_n;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_burst_idx = r_idx;

endmodule

// File: tb/tb_beep_sequencer.sv
// Testbench for beep_sequencer. It uses a table of directed cycle vectors,
// hand-written corner sequences, and randomized traffic. All of it is checked
// against a per-cycle expectation queue that is built from the burst pattern
// rules.
module tb_beep_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] on_c = '0;
  logic [31:0] off_c = '0;
  logic [7:0]  reps = '0;
  logic        gen_en_n, busy, done;
  logic [7:0]  burst_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  beep_sequencer #(.DUR_W(32), .REP_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_on_cycles(on_c), .i_off_cycles(off_c), .i_reps(reps),
    .o_gen_en_n(gen_en_n), .o_busy(busy), .o_done(done), .o_burst_idx(burst_idx)
  );

  // ---------------- reference model ----------------
  typedef struct { logic gen; logic done; logic [7:0] idx; } ev_t;
  ev_t  q[$];
  logic exp_gen = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  logic [7:0] exp_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Expand an accepted request into the full list of busy cycles.
  task automatic build_pattern(input logic [31:0] on_v, input logic [31:0] off_v,
                               input logic [7:0] reps_v);
    ev_t e;
    q.delete();
    if (reps_v == 0 || on_v == 0) begin
      e.gen = 1'b1; e.done = 1'b1; e.idx = 8'd0; q.push_back(e);
    end else begin
      for (int b = 0; b < int'(reps_v); b++) begin
        for (int c = 0; c < int'(on_v); c++) begin
          e.gen = 1'b0; e.done = 1'b0; e.idx = 8'(b); q.push_back(e);
        end
        if (b < int'(reps_v) - 1)
          for (int c = 0; c < int'(off_v); c++) begin
            e.gen = 1'b1; e.done = 1'b0; e.idx = 8'(b); q.push_back(e);
          end
      end
      e.gen = 1'b1; e.done = 1'b1; e.idx = reps_v - 8'd1; q.push_back(e);
    end
  endtask

  task automatic model_step();
    ev_t e;
    if (rst) begin
      q.delete();
      exp_gen = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_idx = '0;
    end else if (exp_busy) begin
      if (abort || q.size() == 0) begin
        q.delete();
        exp_gen = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end else begin
        e = q.pop_front();
        exp_gen = e.gen; exp_busy = 1'b1; exp_done = e.done; exp_idx = e.idx;
      end
    end else if (start && !abort) begin
      build_pattern(on_c, off_c, reps);
      e = q.pop_front();
      exp_gen = e.gen; exp_busy = 1'b1; exp_done = e.done; exp_idx = e.idx;
    end else begin
      exp_gen = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end
  endtask

  // One clock: the model consumes the inputs sampled at this edge, and the
  // DUT outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_gen_en_n", 32'(gen_en_n), 32'(exp_gen));
    chk("model_busy", 32'(busy), 32'(exp_busy));
    chk("model_done", 32'(done), 32'(exp_done));
    chk("model_burst_idx", 32'(burst_idx), 32'(exp_idx));
  endtask

  task automatic wait_idle(output int dones);
    int i;
    dones = 0;
    i = 0;
    while (busy && i < 2000) begin
      tick();
      if (done) dones++;
      i++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rst, start, abort;
    logic [31:0] on_v, off_v;
    logic [7:0] reps_v;
    logic gen, bsy, dn;
    logic [7:0] idx;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mkv(logic st, logic [7:0] rp, logic g, logic b, logic d, logic [7:0] ix);
    vec_t v;
    v.rst = 1'b0; v.start = st; v.abort = 1'b0;
    v.on_v = 32'd4; v.off_v = 32'd3; v.reps_v = rp;
    v.gen = g; v.bsy = b; v.dn = d; v.idx = ix;
    return v;
  endfunction

  initial begin
    int dones;
    // Row i holds the inputs sampled at edge i and the outputs expected in cycle i+1.
    tbl[0]  = mkv(1, 2, 0, 1, 0, 0);
    tbl[1]  = mkv(0, 2, 0, 1, 0, 0);
    tbl[2]  = mkv(0, 2, 0, 1, 0, 0);
    tbl[3]  = mkv(1, 9, 0, 1, 0, 0);   // restart attempt while busy
    tbl[4]  = mkv(0, 2, 1, 1, 0, 0);
    tbl[5]  = mkv(0, 2, 1, 1, 0, 0);
    tbl[6]  = mkv(0, 2, 1, 1, 0, 0);
    tbl[7]  = mkv(0, 2, 0, 1, 0, 1);
    tbl[8]  = mkv(0, 2, 0, 1, 0, 1);
    tbl[9]  = mkv(0, 2, 0, 1, 0, 1);
    tbl[10] = mkv(0, 2, 0, 1, 0, 1);
    tbl[11] = mkv(0, 2, 1, 1, 1, 1);
    tbl[12] = mkv(0, 2, 1, 0, 0, 1);
    tbl[13] = mkv(1, 2, 0, 1, 0, 0);   // start right after done is accepted

    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk("reset_gen_en_n", 32'(gen_en_n), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_burst_idx", 32'(burst_idx), 32'd0);
    rst = 1'b0;
    tick();

    // Basic pattern and restart ignored while busy
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
      on_c = tbl[i].on_v; off_c = tbl[i].off_v; reps = tbl[i].reps_v;
      tick();
      chk($sformatf("tbl%0d_gen_en_n", i), 32'(gen_en_n), 32'(tbl[i].gen));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d_burst_idx", i), 32'(burst_idx), 32'(tbl[i].idx));
    end
    start = 1'b0;
    wait_idle(dones);
    chk("second_pattern_done_count", 32'(dones), 32'd1);

    // reps = 0: one busy+done cycle, and the tone never turns on
    start = 1'b1; reps = 8'd0; on_c = 32'd5; off_c = 32'd2;
    tick();
    start = 1'b0;
    chk("zero_reps_busy", 32'(busy), 32'd1);
    chk("zero_reps_done", 32'(done), 32'd1);
    chk("zero_reps_gen_en_n", 32'(gen_en_n), 32'd1);
    tick();
    chk("zero_reps_busy_after", 32'(busy), 32'd0);
    chk("zero_reps_done_after", 32'(done), 32'd0);

    // on = 0 with nonzero reps also completes immediately
    start = 1'b1; reps = 8'd3; on_c = 32'd0;
    tick();
    start = 1'b0;
    chk("zero_on_done", 32'(done), 32'd1);
    chk("zero_on_gen_en_n", 32'(gen_en_n), 32'd1);
    tick();

    // off = 0: back-to-back bursts
    start = 1'b1; on_c = 32'd2; off_c = 32'd0; reps = 8'd3;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
      if (c <= 6) begin
        chk($sformatf("nogap_c%0d_gen_en_n", c), 32'(gen_en_n), 32'd0);
        chk($sformatf("nogap_c%0d_burst_idx", c), 32'(burst_idx), 32'((c - 1) / 2));
      end else begin
        chk("nogap_done", 32'(done), 32'd1);
        chk("nogap_final_idx", 32'(burst_idx), 32'd2);
      end
    end
    tick();

    // Abort in cycle 5
    start = 1'b1; on_c = 32'd10; off_c = 32'd10; reps = 8'd4;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_gen_en_n", 32'(gen_en_n), 32'd1);
    chk("abort_burst_idx", 32'(burst_idx), 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // abort together with start in IDLE: start is ignored
    start = 1'b1; abort = 1'b1; on_c = 32'd3; reps = 8'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_vs_start_busy", 32'(busy), 32'd0);

    // Reset mid-pattern in cycle 6
    start = 1'b1; on_c = 32'd3; off_c = 32'd2; reps = 8'd3;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_gen_en_n", 32'(gen_en_n), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_burst_idx", 32'(burst_idx), 32'd0);
    start = 1'b1; on_c = 32'd2; off_c = 32'd1; reps = 8'd2;
    tick();
    start = 1'b0;
    wait_idle(dones);
    chk("after_rst_done_count", 32'(dones), 32'd1);
    chk("after_rst_final_idx", 32'(burst_idx), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      on_c  = 32'($urandom_range(0, 6));
      off_c = 32'($urandom_range(0, 4));
      reps  = 8'($urandom_range(0, 4));
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    wait_idle(dones);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

Burst scheduler for the square-wave signal generator that drives the buzzer/indicator output. It accepts a burst request and drives the generator's active-low enable through a programmed pattern: N bursts of tone ON, separated by silent gaps. Requesters use a single-cycle start/done handshake. The generator's toggle period is unchanged; this block only gates it.

## Interface
- DUR_W, 32, width of on/off duration fields, in clock cycles
- REP_W, 8, width of burst repetition count
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- abort  in  1  terminate the pattern immediately; level-sampled each cycle
- on_cycles  in  DUR_W  tone-on duration per burst; latched on accepted start
- off_cycles  in  DUR_W  silent gap between bursts; latched on accepted start
- reps  in  REP_W  number of bursts; latched on accepted start
- gen_en_n  out  1  to generator en; 0 = generator runs, 1 = generator held off (signal low)
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on normal completion
- burst_idx  out  REP_W  0-based index of the current burst; holds its last value in IDLE

## Operation
- States: IDLE, ON, OFF, FIN. All outputs are registered.
- Reset values: state IDLE, gen_en_n=1, busy=0, done=0, burst_idx=0, internal counter 0.
- IDLE, start=1, abort=0:
  - Latch on/off/reps.
  - Clear burst_idx.
  - If reps==0 or on_cycles==0, go to FIN. Otherwise go to ON with counter=on_cycles-1.
- ON: gen_en_n=0. The counter decrements each cycle. At counter==0:
  - If burst_idx==reps-1, go to FIN.
  - Else if off_cycles==0, increment burst_idx and reload ON with on_cycles-1.
  - Else go to OFF with counter=off_cycles-1.
- OFF: gen_en_n=1. At counter==0, go to ON with on_cycles-1 and increment burst_idx.
- FIN: gen_en_n=1, done=1 for exactly one cycle, then IDLE.
- No trailing OFF gap after the last burst.
- abort=1 in ON/OFF/FIN: next state IDLE, gen_en_n=1, done not pulsed. burst_idx holds.
- abort=1 together with start in IDLE: abort wins and start is ignored.
- start while busy: ignored, not queued. Input changes during busy have no effect.
- rst has priority over everything. Mid-pattern it returns all outputs to reset values on the next edge.
- Counter arithmetic is unsigned DUR_W bits. The maximum on/off value is 2^DUR_W-1 cycles. No wrap occurs because a zero duration is handled before the counter loads.

## Timing
- Start sampled at edge k → from cycle k+1: busy=1 and gen_en_n=0 (normal case) or done=1 (zero case).
- Each burst holds gen_en_n=0 for exactly on_cycles cycles.
- Each gap holds gen_en_n=1 for exactly off_cycles cycles.
- Total busy duration is reps·on + (reps-1)·off + 1 cycles (FIN included).
- done is asserted in the last busy cycle. busy=0 and a new start is accepted on the cycle after done.
- Abort sampled at edge k → gen_en_n=1 and busy=0 from cycle k+1.

## Test plan
- on=4, off=3, reps=2, start at edge 0 → gen_en_n low cycles 1–4, high 5–7, low 8–11. done=1 in cycle 12. busy high cycles 1–12. burst_idx 0 then 1.
- reps=0, on=5 → busy and done both high in cycle 1 only; gen_en_n stays 1 throughout.
- on=2, off=0, reps=3 → gen_en_n low for 6 consecutive cycles; burst_idx steps 0,1,2; done in cycle 7.
- on=10, off=10, reps=4; abort in cycle 5 → gen_en_n=1 and busy=0 from cycle 6; done never asserted; burst_idx=0.
- During the first test pattern, assert start again with reps=9 at cycle 3 → pattern unchanged. A start at cycle 13 is accepted.
- rst=1 in cycle 6 of a pattern → next cycle all outputs are at reset values. A start afterwards runs a full clean pattern.
